// File: rtl/mux_scan_serializer_pkg.sv
// Shared definitions for the mux scan serializer: widths, FSM encoding and
// the select-counter start/terminal positions as a function of bit order.
package mux_scan_serializer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } ser_state_e;

    function automatic logic [SEL_W-1:0] sel_first(input bit lsb_first);
        return lsb_first ? 3'd0 : 3'd7;
    endfunction

    function automatic logic [SEL_W-1:0] sel_last(input bit lsb_first);
        return lsb_first ? 3'd7 : 3'd0;
    endfunction

endpackage

// File: rtl/mux_scan_serializer_mux8to1.sv
// 8:1 bit-select mux used to pick the current serial bit out of the held word.
module mux8to1
    import mux_scan_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  sel,
    output logic              data_out
);

    always_comb begin
        data_out = 1'b0;
        case (sel)
            3'd0: data_out = data_in[0];
            3'd1: data_out = data_in[1];
            3'd2: data_out = data_in[2];
            3'd3: data_out = data_in[3];
            3'd4: data_out = data_in[4];
            3'd5: data_out = data_in[5];
            3'd6: data_out = data_in[6];
            3'd7: data_out = data_in[7];
            default: data_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_scan_serializer.sv
// Byte-in, bit-out serializer: holds an accepted word and walks an 8:1 mux
// across it, optionally appending an even-parity beat.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame held; in_ready=1, waiting for a word
//   DATA  | presenting data_reg[sel]; sel steps on each accepted beat
//   PAR   | presenting the even-parity bit as the final beat
module mux_scan_serializer
    import mux_scan_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel
);

    localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(LSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(LSB_FIRST);

    ser_state_e        state;
    ser_state_e        state_nxt;
    logic [DATA_W-1:0] data_reg;
    logic              parity_reg;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_step;
    logic              mux_out;
    logic              at_last;
    logic              beat_fire;
    logic              load;

    mux8to1 u_mux (
        .data_in  (data_reg),
        .sel      (sel_q),
        .data_out (mux_out)
    );

    assign sel      = sel_q;
    assign sel_step = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
    // Frame end is a terminal select value, never a counter wrap.
    assign at_last  = (sel_q == SEL_LAST);

    always_comb begin
        state_nxt = state;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                ser_valid = 1'b1;
                ser_out   = mux_out;
                ser_last  = !PARITY_EN && at_last;
                if (ser_ready && at_last) begin
                    if (PARITY_EN) begin
                        state_nxt = PAR;
                    end else begin
                        state_nxt = in_valid ? DATA : IDLE;
                    end
                end
            end
            PAR: begin
                ser_valid = 1'b1;
                ser_out   = parity_reg;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_nxt = in_valid ? DATA : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accepting on the last beat lets back-to-back frames run without a bubble.
    assign beat_fire = ser_valid && ser_ready;
    assign in_ready  = (state == IDLE) || (beat_fire && ser_last);
    assign load      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_reg   <= '0;
            parity_reg <= 1'b0;
            sel_q      <= SEL_FIRST;
        end else begin
            state <= state_nxt;
            if (load) begin
                data_reg   <= in_data;
                parity_reg <= ^in_data;
                sel_q      <= SEL_FIRST;
            end else if (beat_fire && (state == DATA) && !at_last) begin
                sel_q <= sel_step;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer across three parameter sets.
module tb_mux_scan_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       ser_out   [3];
    logic       ser_valid [3];
    logic       ser_ready [3];
    logic       ser_last  [3];
    logic [2:0] sel       [3];

    int n_total = 0;
    int n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: LSB first, no parity   1: MSB first, no parity   2: LSB first, parity
    mux_scan_serializer #(.LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .ser_ready(ser_ready[0]), .ser_last(ser_last[0]), .sel(sel[0]));

    mux_scan_serializer #(.LSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .ser_ready(ser_ready[1]), .ser_last(ser_last[1]), .sel(sel[1]));

    mux_scan_serializer #(.LSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
        .ser_ready(ser_ready[2]), .ser_last(ser_last[2]), .sel(sel[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic accept(input int k, input logic [7:0] w);
        @(negedge clk);
        in_data[k]   = w;
        in_valid[k]  = 1'b1;
        ser_ready[k] = 1'b1;
        #1;
        check($sformatf("u%0d accept in_ready", k), 32'(in_ready[k]), 32'd1);
        check($sformatf("u%0d accept ser_valid", k), 32'(ser_valid[k]), 32'd0);
    endtask

    task automatic check_idle(input int k);
        @(negedge clk);
        in_valid[k]  = 1'b0;
        ser_ready[k] = 1'b1;
        #1;
        check($sformatf("u%0d idle ser_valid", k), 32'(ser_valid[k]), 32'd0);
        check($sformatf("u%0d idle in_ready", k), 32'(in_ready[k]), 32'd1);
    endtask

    // Walks one frame whose word was accepted on the previous edge.
    task automatic run_frame(input int k, input logic [7:0] w, input bit lsb,
                             input bit par_en, input bit exp_par, input logic [3:0] pat,
                             input bit chain, input bit junk, input logic [7:0] next_w);
        int  nb;
        int  b;
        int  c;
        int  s;
        bit  r;
        bit  last;
        logic exp_bit;
        nb = par_en ? 9 : 8;
        b  = 0;
        c  = 0;
        while (b < nb && c < 64) begin
            @(negedge clk);
            r    = pat[c % 4];
            last = (b == nb - 1);
            ser_ready[k] = r;
            in_valid[k]  = chain;
            if (chain && junk && !(r && last))
                in_data[k] = next_w ^ (8'h01 + 8'(c));
            else
                in_data[k] = next_w;
            #1;
            s = lsb ? b : 7 - b;
            exp_bit = (b < 8) ? w[s] : exp_par;
            check($sformatf("u%0d w%02h b%0d ser_valid", k, w, b), 32'(ser_valid[k]), 32'd1);
            check($sformatf("u%0d w%02h b%0d ser_out", k, w, b), 32'(ser_out[k]), 32'(exp_bit));
            check($sformatf("u%0d w%02h b%0d ser_last", k, w, b), 32'(ser_last[k]),
                  32'(par_en ? (b == 8) : (b == 7)));
            check($sformatf("u%0d w%02h b%0d in_ready", k, w, b), 32'(in_ready[k]), 32'(r && last));
            if (b < 8)
                check($sformatf("u%0d w%02h b%0d sel", k, w, b), 32'(sel[k]), 32'(s));
            if (r) b++;
            c++;
        end
        check($sformatf("u%0d w%02h frame complete", k, w), 32'(c < 64), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[i]   = 8'h00;
            in_valid[i]  = 1'b0;
            ser_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d rst in_ready", i), 32'(in_ready[i]), 32'd1);
            check($sformatf("u%0d rst ser_valid", i), 32'(ser_valid[i]), 32'd0);
            check($sformatf("u%0d rst ser_out", i), 32'(ser_out[i]), 32'd0);
            check($sformatf("u%0d rst ser_last", i), 32'(ser_last[i]), 32'd0);
            check($sformatf("u%0d rst sel", i), 32'(sel[i]), (i == 1) ? 32'd7 : 32'd0);
        end
        rst = 1'b0;

        // LSB first, 8'hA5 -> 1,0,1,0,0,1,0,1
        accept(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 8'h00);
        check_idle(0);

        // MSB first with stalls, 8'h81 -> 1,0,0,0,0,0,0,1
        accept(1, 8'h81);
        run_frame(1, 8'h81, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 8'h00);
        check_idle(1);

        // Even parity: 8'h07 -> 1, 8'h03 -> 0
        accept(2, 8'h07);
        run_frame(2, 8'h07, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 8'h00);
        accept(2, 8'h03);
        run_frame(2, 8'h03, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 8'h00);
        check_idle(2);

        // Back-to-back FF then 00 with no bubble
        accept(0, 8'hFF);
        run_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 8'h00);
        run_frame(0, 8'h00, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 8'h00);
        check_idle(0);

        // Reset on beat 4 of 8'h5A (bits 0,1,0,1,...)
        accept(0, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid[0]  = 1'b0;
            ser_ready[0] = 1'b1;
            #1;
            check($sformatf("rst5a b%0d ser_out", i), 32'(ser_out[0]), (i == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst5a b3 ser_out", 32'(ser_out[0]), 32'd1);
        check("rst5a b3 sel", 32'(sel[0]), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst5a after ser_valid", 32'(ser_valid[0]), 32'd0);
        check("rst5a after in_ready", 32'(in_ready[0]), 32'd1);
        check("rst5a after sel", 32'(sel[0]), 32'd0);
        check("rst5a after ser_last", 32'(ser_last[0]), 32'd0);
        check("rst5a after ser_out", 32'(ser_out[0]), 32'd0);
        accept(0, 8'h3C);
        run_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 8'h00);
        check_idle(0);

        // in_data churns mid-frame; 8'h96 is taken only on the last beat
        accept(0, 8'hC3);
        run_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 8'h96);
        run_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 8'h00);
        check_idle(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
